// File: rtl/ex_div_seq_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_seq_pkg
// Shared EX-stage definitions used by the iterative divider sequencer.
//   XLEN / WLEN            : operand width and width of W-variant ops
//   div_op_e               : funct encoding of the four divide/remainder ops
//   div_state_e            : sequencer FSM encoding
//   interconnection_struct : stall/staller fields passed between stages
//   div_fixup()            : sign and special-case correction of a raw result
// ---------------------------------------------------------------------------
package ex_div_seq_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  typedef struct packed {
    logic stall;
    logic is_staller;
  } interconnection_struct;

  // Turns unsigned quotient/remainder magnitudes into the architectural
  // result. Divide-by-zero and signed overflow override the magnitudes, so
  // the caller may pass anything for them in those cases. W results keep
  // only the low WLEN bits; the downstream stage sign-extends them.
  function automatic logic [XLEN-1:0] div_fixup(
    input logic            is_rem,
    input logic            is_word,
    input logic            q_neg,
    input logic            r_neg,
    input logic            div_zero,
    input logic            ovf,
    input logic [XLEN-1:0] quo_mag,
    input logic [XLEN-1:0] rem_mag,
    input logic [XLEN-1:0] dividend
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] res;
    q = q_neg ? (~quo_mag + 1'b1) : quo_mag;
    r = r_neg ? (~rem_mag + 1'b1) : rem_mag;
    if (div_zero) begin
      q = '1;
      r = dividend;
    end else if (ovf) begin
      q = dividend;
      r = '0;
    end
    res = is_rem ? r : q;
    if (is_word) begin
      res = {{(XLEN-WLEN){1'b0}}, res[WLEN-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// ---------------------------------------------------------------------------
// ex_div_core
// One step of a radix-2 restoring divider, purely combinational.
//   rem      : partial remainder (always < dvsr between steps)
//   quo      : dividend bits still to be consumed (MSB first) with the
//              quotient bits developed so far shifted in at the bottom
//   dvsr     : divisor magnitude
//   rem_next : partial remainder after shift / trial subtract / restore
//   quo_next : quo shifted left with the new quotient bit in bit 0
// ---------------------------------------------------------------------------
module ex_div_core
  import ex_div_seq_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  assign rem_sh = {rem, quo[XLEN-1]};

  // The shifted remainder is XLEN+1 bits wide. When its top bit is set it
  // always exceeds the divisor and the low XLEN bits of the difference are
  // exact, so only an XLEN-bit subtract with borrow is needed.
  assign diff     = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, dvsr};
  assign fits     = rem_sh[XLEN] | ~diff[XLEN];
  assign rem_next = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/ex_div_seq.sv
// ---------------------------------------------------------------------------
// ex_div_seq
// Sequencer for the shared iterative restoring divider in EX. Serves DIV,
// DIVU, REM, REMU and their W variants, stalling the pipeline while it
// iterates one quotient bit per cycle.
//   clk, rst       : clock, synchronous active-high reset
//   i_start        : valid divide op present in EX
//   i_op           : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_is_word      : W variant (operates on bits [31:0])
//   i_rs1, i_rs2   : dividend, divisor
//   i_flush        : abort the op, no o_done pulse
//   o_stall        : hold upstream stages
//   o_is_staller   : EX is the stall source
//   o_done         : one-cycle result-valid pulse
//   o_result       : quotient or remainder, held until the next o_done
//   o_en_sign_ext  : result must be sign-extended from bit 31
// Build option: RIVIERA_DIV_FAST_SPECIAL_EN finishes divide-by-zero and
// signed overflow straight from IDLE (o_done one cycle after start).
// ---------------------------------------------------------------------------
module ex_div_seq
  import ex_div_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic            i_is_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_is_staller,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_en_sign_ext
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMIN = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  logic [1:0]      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] dvsr_reg;
  logic [XLEN-1:0] dividend_reg;
  logic            is_rem_reg;
  logic            word_reg;
  logic            q_neg_reg;
  logic            r_neg_reg;
  logic            zero_reg;
  logic            ovf_reg;
  logic [XLEN-1:0] result_reg;
  logic            sext_reg;

  // ---- operand capture ----------------------------------------------------
  logic            cap_signed;
  logic [XLEN-1:0] cap_a;
  logic [XLEN-1:0] cap_b;
  logic            cap_a_neg;
  logic            cap_b_neg;
  logic [XLEN-1:0] cap_a_mag;
  logic [XLEN-1:0] cap_b_mag;
  logic [XLEN-1:0] cap_quo;
  logic            cap_zero;
  logic            cap_ovf;
  logic            accept;

  always_comb begin
    cap_signed = ~i_op[0];
    if (i_is_word) begin
      cap_a = {{(XLEN-WLEN){cap_signed & i_rs1[WLEN-1]}}, i_rs1[WLEN-1:0]};
      cap_b = {{(XLEN-WLEN){cap_signed & i_rs2[WLEN-1]}}, i_rs2[WLEN-1:0]};
    end else begin
      cap_a = i_rs1;
      cap_b = i_rs2;
    end
    cap_a_neg = cap_signed & cap_a[XLEN-1];
    cap_b_neg = cap_signed & cap_b[XLEN-1];
    cap_a_mag = cap_a_neg ? (~cap_a + 1'b1) : cap_a;
    cap_b_mag = cap_b_neg ? (~cap_b + 1'b1) : cap_b;
    // W dividends are left-aligned so the core consumes them MSB first and
    // the quotient lands in the low WLEN bits after WLEN steps.
    cap_quo   = i_is_word ? {cap_a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : cap_a_mag;
    cap_zero  = (cap_b == '0);
    // Operands are already extended to XLEN, so one compare covers both widths.
    cap_ovf   = cap_signed && (cap_b == '1) &&
                (cap_a == (i_is_word ? WMIN : XMIN));
  end

  assign accept = (state_reg == S_IDLE) && i_start && !i_flush;

  // ---- datapath step ------------------------------------------------------
  logic [XLEN-1:0] core_rem_next;
  logic [XLEN-1:0] core_quo_next;

  ex_div_core u_core (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvsr     (dvsr_reg),
    .rem_next (core_rem_next),
    .quo_next (core_quo_next)
  );

  // Result of the final iteration, fixed up while entering DONE.
  logic [XLEN-1:0] busy_result;
  assign busy_result = div_fixup(is_rem_reg, word_reg, q_neg_reg, r_neg_reg,
                                 zero_reg, ovf_reg, core_quo_next,
                                 core_rem_next, dividend_reg);

`ifdef RIVIERA_DIV_FAST_SPECIAL_EN
  // Special cases ignore the magnitudes, so zeros are passed for them.
  logic [XLEN-1:0] fast_result;
  assign fast_result = div_fixup(i_op[1], i_is_word, 1'b0, 1'b0, cap_zero,
                                 cap_ovf, '0, '0, cap_a);
`endif

  // ---- FSM ----------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvsr_reg     <= '0;
      dividend_reg <= '0;
      is_rem_reg   <= 1'b0;
      word_reg     <= 1'b0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      result_reg   <= '0;
      sext_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            rem_reg      <= '0;
            quo_reg      <= cap_quo;
            dvsr_reg     <= cap_b_mag;
            dividend_reg <= cap_a;
            is_rem_reg   <= i_op[1];
            word_reg     <= i_is_word;
            q_neg_reg    <= cap_a_neg ^ cap_b_neg;
            r_neg_reg    <= cap_a_neg;
            zero_reg     <= cap_zero;
            ovf_reg      <= cap_ovf;
            cnt_reg      <= i_is_word ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
            state_reg    <= S_BUSY;
`ifdef RIVIERA_DIV_FAST_SPECIAL_EN
            if (cap_zero || cap_ovf) begin
              cnt_reg    <= '0;
              result_reg <= fast_result;
              sext_reg   <= i_is_word;
              state_reg  <= S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          if (i_flush) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else begin
            rem_reg <= core_rem_next;
            quo_reg <= core_quo_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
              result_reg <= busy_result;
              sext_reg   <= word_reg;
              state_reg  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---- outputs ------------------------------------------------------------
  interconnection_struct staller;
  assign staller.stall      = accept || (state_reg == S_BUSY);
  assign staller.is_staller = staller.stall;

  assign o_stall       = staller.stall;
  assign o_is_staller  = staller.is_staller;
  // A flush landing on the DONE cycle squashes the op, so no pulse then.
  assign o_done        = (state_reg == S_DONE) && !i_flush;
  assign o_result      = result_reg;
  assign o_en_sign_ext = sext_reg;

endmodule

// File: tb/tb_ex_div_seq.sv
// ---------------------------------------------------------------------------
// tb_ex_div_seq
// Self-checking bench for ex_div_seq: directed vector table, hand-written
// flush/reset sequences and randomized ops compared against an arithmetic
// reference model. Honours RIVIERA_DIV_FAST_SPECIAL_EN for expected latency.
// ---------------------------------------------------------------------------
module tb_ex_div_seq;
  import ex_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic        i_is_word;
  logic [63:0] i_rs1;
  logic [63:0] i_rs2;
  logic        i_flush;
  logic        o_stall;
  logic        o_is_staller;
  logic        o_done;
  logic [63:0] o_result;
  logic        o_en_sign_ext;

  ex_div_seq dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_is_word     (i_is_word),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .o_is_staller  (o_is_staller),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_en_sign_ext (o_en_sign_ext)
  );

  always #5 clk = ~clk;

`ifdef RIVIERA_DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the architectural rules -------
  function automatic bit ref_special(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    bit sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (w)
      return (b[31:0] == 32'h0) ||
             (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) ||
           (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [63:0] r;
    logic [31:0] r32;
    bit ovf;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    if (w) begin
      ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      case (op)
        2'd0: if (b[31:0] == 0) r32 = 32'hFFFF_FFFF; else if (ovf) r32 = a[31:0]; else r32 = sa32 / sb32;
        2'd1: if (b[31:0] == 0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
        2'd2: if (b[31:0] == 0) r32 = a[31:0]; else if (ovf) r32 = 32'h0; else r32 = sa32 % sb32;
        default: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      endcase
      return {32'h0, r32};
    end
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    case (op)
      2'd0: if (b == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
      2'd1: if (b == 0) r = '1; else r = a / b;
      2'd2: if (b == 0) r = a; else if (ovf) r = 64'h0; else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    if (FAST && ref_special(op, w, a, b)) return 1;
    return w ? 33 : 65;
  endfunction

  // ---- one complete op: start, watch stall, wait for done, check ----------
  task automatic do_op(input string name, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat);
    int cyc;
    bit seen;
    bit stall_ok;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_is_word = w; i_rs1 = a; i_rs2 = b; i_flush = 1'b0;
    #1;
    chk({name, "_stall_start"}, 64'(o_stall), 64'd1);
    chk({name, "_staller_start"}, 64'(o_is_staller), 64'd1);
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      // Garbage requests while busy must be ignored.
      i_start = 1'($urandom_range(0, 1));
      i_op = 2'($urandom_range(0, 3));
      i_is_word = 1'($urandom_range(0, 1));
      i_rs1 = {$urandom, $urandom};
      i_rs2 = {$urandom, $urandom};
      cyc++;
      #1;
      if (o_done) seen = 1'b1;
      else if (!(o_stall && o_is_staller)) stall_ok = 1'b0;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_stall_busy"}, 64'(stall_ok), 64'd1);
    if (seen) begin
      chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({name, "_result"}, o_result, exp_res);
      chk({name, "_sext"}, 64'(o_en_sign_ext), 64'(w));
      chk({name, "_stall_done"}, 64'(o_stall | o_is_staller), 64'd0);
    end
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk({name, "_done_pulse"}, 64'(o_done), 64'd0);
    chk({name, "_hold"}, o_result, exp_res);
    $display("op=%0d w=%0d rs1=%h rs2=%h result=%h exp=%h lat=%0d", op, w, a, b,
             o_result, exp_res, cyc);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat_sp;
    bit any_done;
    bit any_stall;
    logic [63:0] prev;
    logic [1:0] rop;
    logic rw;
    logic [63:0] ra, rb;

    lat_sp = FAST ? 1 : 65;
    vecs[0] = '{"divu_100_7",   2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[1] = '{"remw_m7_2",    2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                64'h0000_0000_FFFF_FFFF, 33};
    vecs[2] = '{"div_by_zero",  2'd0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat_sp};
    vecs[3] = '{"div_ovf",      2'd0, 1'b0, 64'h8000_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, lat_sp};
    vecs[4] = '{"rem_ovf",      2'd2, 1'b0, 64'h8000_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0, lat_sp};
    vecs[5] = '{"remu_by_zero", 2'd3, 1'b0, 64'd123, 64'd0, 64'd123, lat_sp};
    vecs[6] = '{"divw_m20_3",   2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                64'h0000_0000_FFFF_FFFA, 33};
    vecs[7] = '{"divuw_hi_junk", 2'd1, 1'b1, 64'hFFFF_FFFF_0000_0064,
                64'h0000_0001_0000_0007, 64'd14, 33};

    rst = 1'b1; i_start = 1'b0; i_op = 2'd0; i_is_word = 1'b0;
    i_rs1 = '0; i_rs2 = '0; i_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", 64'(o_stall), 64'd0);
    chk("reset_staller", 64'(o_is_staller), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_result", o_result, 64'd0);
    chk("reset_sext", 64'(o_en_sign_ext), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat);

    // Flush together with start in IDLE: not accepted.
    prev = o_result;
    @(negedge clk);
    i_start = 1'b1; i_flush = 1'b1; i_op = 2'd1; i_is_word = 1'b0;
    i_rs1 = 64'd50; i_rs2 = 64'd5;
    #1;
    chk("flush_start_stall", 64'(o_stall), 64'd0);
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    any_done = 1'b0; any_stall = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      #1;
      any_done |= o_done; any_stall |= o_stall;
    end
    chk("flush_start_no_done", 64'(any_done), 64'd0);
    chk("flush_start_no_stall", 64'(any_stall), 64'd0);
    $display("flush+start in idle: stall=%0d done_seen=%0d", any_stall, any_done);

    // Flush at T+10 of a DIV.
    @(negedge clk);
    i_start = 1'b1; i_op = 2'd0; i_is_word = 1'b0; i_rs1 = 64'd1000; i_rs2 = 64'd7;
    #1;
    any_stall = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i_start = 1'b0; i_flush = (c == 10);
      #1;
      if (c < 10) any_stall &= o_stall;
      else chk("flush_t10_done", 64'(o_done), 64'd0);
    end
    chk("flush_busy_stall", 64'(any_stall), 64'd1);
    any_done = 1'b0; any_stall = 1'b0;
    for (int c = 11; c <= 80; c++) begin
      @(negedge clk);
      i_flush = 1'b0;
      #1;
      any_done |= o_done; any_stall |= o_stall;
    end
    chk("flush_no_done", 64'(any_done), 64'd0);
    chk("flush_stall_low", 64'(any_stall), 64'd0);
    chk("flush_result_kept", o_result, prev);
    $display("flush at T+10: stall_after=%0d done_seen=%0d result=%h", any_stall,
             any_done, o_result);

    // Reset at T+20, new DIVU 9/3 at T+25 -> done at T+90.
    @(negedge clk);
    i_start = 1'b1; i_op = 2'd0; i_is_word = 1'b0; i_rs1 = 64'd12345;
    i_rs2 = 64'hFFFF_FFFF_FFFF_FFEF;
    #1;
    any_done = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      i_start = (c == 25);
      rst = (c == 20);
      if (c == 25) begin
        i_op = 2'd1; i_is_word = 1'b0; i_rs1 = 64'd9; i_rs2 = 64'd3;
      end
      #1;
      if (c == 21) begin
        chk("rst_mid_stall", 64'(o_stall), 64'd0);
        chk("rst_mid_result", o_result, 64'd0);
        chk("rst_mid_sext", 64'(o_en_sign_ext), 64'd0);
      end
      if (c < 90) any_done |= o_done;
      else begin
        chk("rst_new_done", 64'(o_done), 64'd1);
        chk("rst_new_result", o_result, 64'd3);
      end
    end
    chk("rst_no_early_done", 64'(any_done), 64'd0);
    $display("rst mid-op then divu 9/3: result=%h", o_result);
    @(negedge clk);
    i_start = 1'b0;

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      ra  = pick();
      rb  = pick();
      do_op($sformatf("rand%0d", n), rop, rw, ra, rb, ref_result(rop, rw, ra, rb),
            ref_latency(rop, rw, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
